// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the flagged synchronous FIFO.
package fifo_pkg;

    localparam int unsigned DefBits  = 8;
    localparam int unsigned DefDepth = 8;

    function automatic int unsigned ptr_width(input int unsigned d);
        return $clog2(d);
    endfunction

    // One extra bit so the count can hold the value depth itself.
    function automatic int unsigned cnt_width(input int unsigned d);
        return $clog2(d) + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer with increment enable, synchronous clear and async active-low reset.
module fifo_ptr #(
    parameter int unsigned Width = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] ptr_o
);

    logic [Width-1:0] ptr_d, ptr_q;

    // Power-of-two depth: natural overflow of the adder gives the wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_flags.sv
// First-word fall-through synchronous FIFO with occupancy count, level flags and
// registered overflow/underflow pulses.
module fifo_flags
    import fifo_pkg::*;
#(
    parameter int unsigned bits     = DefBits,
    parameter int unsigned depth    = DefDepth,
    parameter int unsigned af_level = depth - 1,
    parameter int unsigned ae_level = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [bits-1:0]             Din,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        clr,
    output logic [bits-1:0]             Dout,
    output logic                        full,
    output logic                        pndng,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [cnt_width(depth)-1:0] count,
    output logic                        ovf,
    output logic                        udf
);

    localparam int unsigned PtrW = ptr_width(depth);
    localparam int unsigned CntW = cnt_width(depth);

    localparam logic [CntW-1:0] DepthCnt = CntW'(depth);
    localparam logic [CntW-1:0] AfCnt    = CntW'(af_level);
    localparam logic [CntW-1:0] AeCnt    = CntW'(ae_level);

    logic [bits-1:0] mem_q [depth];

    logic [PtrW-1:0] wr_ptr, rd_ptr;
    logic [CntW-1:0] count_d, count_q;
    logic            ovf_d, ovf_q;
    logic            udf_d, udf_q;
    logic            wr_en, rd_en;

    assign full  = (count_q == DepthCnt);
    assign pndng = (count_q != '0);

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign rd_en = pop & pndng;
    assign wr_en = push & (~full | rd_en);

    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
        if (clr) begin
            count_d = '0;
        end else begin
            ovf_d = push & ~wr_en;
            udf_d = pop & ~pndng;
            if (wr_en && !rd_en) begin
                count_d = count_q + CntW'(1);
            end else if (rd_en && !wr_en) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clr) begin
            mem_q[wr_ptr] <= Din;
        end
    end

    fifo_ptr #(
        .Width (PtrW)
    ) u_wr_ptr (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (clr),
        .inc_i  (wr_en),
        .ptr_o  (wr_ptr)
    );

    fifo_ptr #(
        .Width (PtrW)
    ) u_rd_ptr (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (clr),
        .inc_i  (rd_en),
        .ptr_o  (rd_ptr)
    );

    assign Dout         = pndng ? mem_q[rd_ptr] : '0;
    assign almost_full  = (count_q >= AfCnt);
    assign almost_empty = (count_q <= AeCnt);
    assign count        = count_q;
    assign ovf          = ovf_q;
    assign udf          = udf_q;

endmodule

// File: doc/fifo_flags.md
FIFO_FLAGS -- requirements
Module: fifo_flags

Interface
REQ-001 Parameter bits, default 8, data word width in bits (>=1).
REQ-002 Parameter depth, default 8, number of storage entries (power of two, >=2).
REQ-003 Parameter af_level, default depth-1, count at or above which almost_full is asserted.
REQ-004 Parameter ae_level, default 1, count at or below which almost_empty is asserted.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 Din  input  bits  write data, sampled on a clk edge with push=1.
REQ-008 push  input  1  write request.
REQ-009 pop  input  1  read request; consumes the entry currently on Dout.
REQ-010 clr  input  1  synchronous flush; empties the FIFO on the next clk edge.
REQ-011 Dout  output  bits  oldest stored entry (first-word fall-through).
REQ-012 full  output  1  count == depth.
REQ-013 pndng  output  1  count != 0 (data pending).
REQ-014 almost_full  output  1  count >= af_level.
REQ-015 almost_empty  output  1  count <= ae_level.
REQ-016 count  output  $clog2(depth)+1  number of stored entries, 0..depth.
REQ-017 ovf  output  1  one-cycle pulse: push rejected because full.
REQ-018 udf  output  1  one-cycle pulse: pop rejected because empty.

Function
REQ-019 Write accepted iff push=1 and (full=0, or pop=1 with pndng=1); Din stored at wr_ptr, wr_ptr increments.
REQ-020 Read accepted iff pop=1 and pndng=1; rd_ptr increments.
REQ-021 Pointers are $clog2(depth) bits and wrap from depth-1 to 0 with no extra logic.
REQ-022 count: +1 on write-only, -1 on read-only, unchanged on both or neither.
REQ-023 Push and pop when full: both accepted, count stays depth, ovf=0.
REQ-024 Push and pop when empty: push accepted, pop rejected, udf=1, count becomes 1.
REQ-025 Push when full without pop: Din discarded, memory and pointers unchanged, ovf=1 for one cycle.
REQ-026 Pop when empty: no state change, udf=1 for one cycle.
REQ-027 Dout = mem[rd_ptr] combinationally when pndng=1; Dout = 0 when pndng=0.
REQ-028 Written data appears on Dout the cycle after the write edge when the FIFO was empty (one-cycle latency).
REQ-029 full, pndng, almost_full, almost_empty decode combinationally from registered count only.
REQ-030 ovf and udf are registered; each is high exactly one cycle per rejected request.
REQ-031 clr=1 has priority over push/pop: pointers and count go to 0, ovf/udf go to 0, memory contents need not be cleared.

Reset
REQ-032 rst=0 asynchronously sets wr_ptr, rd_ptr, count, ovf, udf to 0, regardless of clk.
REQ-033 During and after reset: full=0, pndng=0, almost_full=0 (af_level>=1), almost_empty=1, Dout=0, count=0.
REQ-034 Reset mid-operation discards all stored entries; the first push after release appears on Dout after one cycle.
REQ-035 Storage array has no reset.

Structure
REQ-036 Package fifo_pkg holds the default bits/depth constants and the pointer/count width functions.
REQ-037 One sub-module fifo_ptr (wrapping pointer with increment enable, async active-low reset, sync clear), instantiated twice.
REQ-038 Storage is a bits x depth register array in fifo_flags; no tristate demux.

Verification
REQ-039 Reset, then 8 pushes of 0x01..0x08 (depth=8) -> full=1 after the 8th, count=8, almost_full=1 from count 7.
REQ-040 Full FIFO, push 0xAA -> ovf=1 for one cycle, 8 pops return 0x01..0x08 in order, then pndng=0, Dout=0.
REQ-041 Empty FIFO, push 0x55 and pop together -> udf=1, count=1, Dout=0x55 next cycle.
REQ-042 Full FIFO, push 0x99 and pop together for 10 cycles -> count stays 8, no ovf, output order preserved across pointer wrap.
REQ-043 count=5, assert rst low between edges -> count=0, pndng=0 immediately; clr=1 at count=3 -> count=0 next edge.
